clut_prom_responder: RTL and testbench

- Responder end of the colour-lookup PROM bus used by the video generator.
- Models PROM 3R (512x8, red/green nibbles) and PROM 3S (512x4, blue) as loadable arrays. Answers PROM address/chip-enable requests with PROM-style data.
- Images arrive as a byte stream over a valid/ready load port, sequenced by a load state machine. Replaces fixed ROM images in simulation and FPGA builds.

---
 rtl/clut_prom_responder.sv | 190 +++++++++++++++++++
 tb/tb_clut_prom_responder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clut_prom_responder.sv
`default_nettype none
// ============================================================================
//  Module   : clut_prom_responder
//  Purpose  : Responder end of the colour-lookup PROM bus. Holds loadable
//             images of PROM 3R (red/green nibbles, 8 bit) and PROM 3S
//             (blue, 4 bit), filled from a valid/ready byte stream, and
//             answers chip-enable/address requests with PROM-style data.
//  Options  : define CLUT_PROM_CHECKSUM_EN to require a trailing checksum
//             byte after the 1024 image bytes (adds the CHECK state).
//  Revision : 1.0 - initial release
// ============================================================================
module clut_prom_responder #(
    parameter int         ADDR_WIDTH    = 9,
    parameter logic [7:0] UNLOADED_DATA = 8'h00
) (
    input  logic                  CLK_6MD,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic [7:0]            load_data,
    input  logic                  load_valid,
    output logic                  load_ready,
    output logic                  load_busy,
    output logic                  loaded,
    output logic                  load_error,
    input  logic [ADDR_WIDTH-1:0] prom_3r_addr,
    input  logic                  prom_3r_ce_n,
    output logic [7:0]            prom_3r_data,
    input  logic [ADDR_WIDTH-1:0] prom_3s_addr,
    input  logic                  prom_3s_ce_n,
    output logic [3:0]            prom_3s_data
);

    localparam int                    c_DEPTH       = 2**ADDR_WIDTH;
    localparam logic [3:0]            c_UNLOADED_3S = UNLOADED_DATA[3:0];
    localparam logic [ADDR_WIDTH-1:0] c_CNT_ONE     = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_3R = 3'd1,
        S_LOAD_3S = 3'd2,
        S_CHECK   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    wr_3r, wr_3s;
    logic                    w_beat;
    logic                    w_last;

    // Image storage; contents survive reset and are only hidden by 'loaded'.
    logic [7:0]              mem_3r_q [c_DEPTH];
    logic [3:0]              mem_3s_q [c_DEPTH];

`ifdef CLUT_PROM_CHECKSUM_EN
    logic [7:0]              acc_q, acc_d;
    logic                    err_q, err_d;
    logic [7:0]              w_sum;
`endif

    // The responder takes bytes only while a load is in flight.
    assign load_ready = (state_q == S_LOAD_3R) || (state_q == S_LOAD_3S) ||
                        (state_q == S_CHECK);
    assign load_busy  = load_ready;
    assign loaded     = (state_q == S_DONE);
    assign w_beat     = load_valid & load_ready;
    assign w_last     = &cnt_q;

`ifdef CLUT_PROM_CHECKSUM_EN
    assign w_sum      = acc_q + load_data;
    assign load_error = err_q;
`else
    assign load_error = 1'b0;
`endif

    // State, address counter and checksum registers.
    always_ff @(posedge CLK_6MD) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
`ifdef CLUT_PROM_CHECKSUM_EN
            acc_q   <= 8'h00;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
`ifdef CLUT_PROM_CHECKSUM_EN
            acc_q   <= acc_d;
            err_q   <= err_d;
`endif
        end
    end

    // Load sequencer: next state, counter advance and array write strobes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_3r   = 1'b0;
        wr_3s   = 1'b0;
`ifdef CLUT_PROM_CHECKSUM_EN
        acc_d   = acc_q;
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (load_start) begin
                    state_d = S_LOAD_3R;
                    cnt_d   = '0;
`ifdef CLUT_PROM_CHECKSUM_EN
                    acc_d   = 8'h00;
                    err_d   = 1'b0;
`endif
                end
            end
            S_LOAD_3R: begin
                if (w_beat) begin
                    wr_3r = 1'b1;
                    cnt_d = cnt_q + c_CNT_ONE;
`ifdef CLUT_PROM_CHECKSUM_EN
                    acc_d = w_sum;
`endif
                    if (w_last) begin
                        state_d = S_LOAD_3S;
                    end
                end
            end
            S_LOAD_3S: begin
                if (w_beat) begin
                    wr_3s = 1'b1;
                    cnt_d = cnt_q + c_CNT_ONE;
`ifdef CLUT_PROM_CHECKSUM_EN
                    // Checksum covers the whole byte, discarded nibble included.
                    acc_d = w_sum;
                    if (w_last) begin
                        state_d = S_CHECK;
                    end
`else
                    if (w_last) begin
                        state_d = S_DONE;
                    end
`endif
                end
            end
`ifdef CLUT_PROM_CHECKSUM_EN
            S_CHECK: begin
                if (w_beat) begin
                    if (w_sum == 8'h00) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Array writes; suppressed during reset so an aborting cycle leaves no trace.
    always_ff @(posedge CLK_6MD) begin
        if (!rst && wr_3r) begin
            mem_3r_q[cnt_q] <= load_data;
        end
        if (!rst && wr_3s) begin
            mem_3s_q[cnt_q] <= load_data[3:0];
        end
    end

    // PROM 3R read: pull-up when deselected, blank value until images are valid.
    always_comb begin
        prom_3r_data = 8'hFF;
        if (!prom_3r_ce_n) begin
            prom_3r_data = loaded ? mem_3r_q[prom_3r_addr] : UNLOADED_DATA;
        end
    end

    // PROM 3S read: same behaviour on the 4-bit blue PROM.
    always_comb begin
        prom_3s_data = 4'hF;
        if (!prom_3s_ce_n) begin
            prom_3s_data = loaded ? mem_3s_q[prom_3s_addr] : c_UNLOADED_3S;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_clut_prom_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clut_prom_responder
//  Purpose  : Self-checking bench for clut_prom_responder. A byte-list model
//             (byte k lands in 3R[k] for k<512, else in 3S[k-512]) predicts
//             read data and load status.
//  Options  : CLUT_PROM_CHECKSUM_EN selects the checksum-enabled build.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_clut_prom_responder;

    localparam int AW    = 9;
    localparam int DEPTH = 512;
`ifdef CLUT_PROM_CHECKSUM_EN
    localparam int NBYTES = 2*DEPTH + 1;
`else
    localparam int NBYTES = 2*DEPTH;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          load_start;
    logic [7:0]    load_data;
    logic          load_valid;
    logic          load_ready;
    logic          load_busy;
    logic          loaded;
    logic          load_error;
    logic [AW-1:0] prom_3r_addr;
    logic          prom_3r_ce_n;
    logic [7:0]    prom_3r_data;
    logic [AW-1:0] prom_3s_addr;
    logic          prom_3s_ce_n;
    logic [3:0]    prom_3s_data;

    always #5 clk = ~clk;

    clut_prom_responder #(
        .ADDR_WIDTH    (AW),
        .UNLOADED_DATA (8'h00)
    ) dut (
        .CLK_6MD      (clk),
        .rst          (rst),
        .load_start   (load_start),
        .load_data    (load_data),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_busy    (load_busy),
        .loaded       (loaded),
        .load_error   (load_error),
        .prom_3r_addr (prom_3r_addr),
        .prom_3r_ce_n (prom_3r_ce_n),
        .prom_3r_data (prom_3r_data),
        .prom_3s_addr (prom_3s_addr),
        .prom_3s_ce_n (prom_3s_ce_n),
        .prom_3s_data (prom_3s_data)
    );

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [7:0] m3r [DEPTH];
    logic [3:0] m3s [DEPTH];
    bit         m_loaded;
    bit         m_err;
    logic [7:0] stream [NBYTES];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // kind 0: i & 8'hFF, kind 1: random bytes, kind 2: all 8'h01.
    // bad_cs makes the trailing checksum byte off by one (checksum build only).
    task automatic fill(input int kind, input bit bad_cs);
        int sum;
        sum = 0;
        for (int i = 0; i < 2*DEPTH; i++) begin
            case (kind)
                0:       stream[i] = 8'(i);
                1:       stream[i] = 8'($urandom_range(0, 255));
                default: stream[i] = 8'h01;
            endcase
            sum += int'(stream[i]);
        end
`ifdef CLUT_PROM_CHECKSUM_EN
        stream[NBYTES-1] = 8'((256 - (sum % 256)) % 256 + (bad_cs ? 1 : 0));
`else
        if (bad_cs) sum = 0;
`endif
    endtask

    // Images count as loaded if every byte went in and (with checksum) the total wraps to zero.
    function automatic bit stream_ok();
        int sum;
        sum = 0;
        for (int i = 0; i < NBYTES; i++) sum += int'(stream[i]);
`ifdef CLUT_PROM_CHECKSUM_EN
        return (sum % 256) == 0;
`else
        return 1'b1;
`endif
    endfunction

    task automatic check_reads(input int n);
        for (int k = 0; k < n; k++) begin
            logic [AW-1:0] a3r, a3s;
            logic          c3r, c3s;
            logic [7:0]    e3r;
            logic [3:0]    e3s;
            a3r = AW'($urandom_range(0, DEPTH-1));
            a3s = AW'($urandom_range(0, DEPTH-1));
            c3r = ($urandom_range(0, 3) == 0);
            c3s = ($urandom_range(0, 3) == 0);
            e3r = c3r ? 8'hFF : (m_loaded ? m3r[a3r] : 8'h00);
            e3s = c3s ? 4'hF  : (m_loaded ? m3s[a3s] : 4'h0);
            @(negedge clk);
            prom_3r_addr = a3r; prom_3r_ce_n = c3r;
            prom_3s_addr = a3s; prom_3s_ce_n = c3s;
            #1;
            check("rand_read_3r", prom_3r_data, e3r);
            check("rand_read_3s", prom_3s_data, e3s);
        end
    endtask

    // mode 0: valid held, 1: valid toggles, 2: random valid.
    task automatic run_load(input int mode, input int abort_at, input int pulse_at);
        int  idx, cyc;
        bit  v, beat, early;
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        m_loaded = 1'b0;
        m_err    = 1'b0;
        check("start_loaded_low", loaded, 0);
        check("start_busy", load_busy, 1);
        check("start_err_clear", load_error, 0);
        idx = 0; cyc = 0; early = 1'b0;
        while (idx < NBYTES && cyc < 8*NBYTES) begin
            if (idx == abort_at) begin
                rst = 1'b1; load_valid = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                check("abort_busy", load_busy, 0);
                check("abort_loaded", loaded, 0);
                return;
            end
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = ($urandom_range(0, 1) == 1);
            endcase
            load_valid = v;
            load_data  = stream[idx];
            load_start = (idx == pulse_at);
            if (idx == 50) begin
                prom_3r_addr = AW'($urandom_range(0, DEPTH-1));
                prom_3r_ce_n = 1'b0;
                #1;
                check("read_during_load", prom_3r_data, 8'h00);
            end
            beat = v && load_ready;
            @(negedge clk);
            cyc++;
            if (beat) begin
                if (idx < DEPTH)        m3r[idx] = stream[idx];
                else if (idx < 2*DEPTH) m3s[idx-DEPTH] = stream[idx][3:0];
                idx++;
            end
            if (idx < NBYTES && loaded) early = 1'b1;
        end
        load_valid = 1'b0;
        load_start = 1'b0;
        check("beat_count", idx, NBYTES);
        check("no_early_loaded", early, 0);
        if (mode == 0) check("one_beat_per_cycle", cyc, NBYTES);
        m_loaded = stream_ok();
        m_err    = !m_loaded;
        check("end_loaded", loaded, m_loaded);
        check("end_error", load_error, m_err);
        check("end_busy", load_busy, 0);
        check("end_ready", load_ready, 0);
    endtask

    initial begin
        rst = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_data = 8'h00;
        prom_3r_addr = '0; prom_3r_ce_n = 1'b1;
        prom_3s_addr = '0; prom_3s_ce_n = 1'b1;
        m_loaded = 1'b0; m_err = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state and unloaded/deselected reads.
        prom_3r_addr = 9'h005; prom_3r_ce_n = 1'b0;
        prom_3s_addr = 9'h005; prom_3s_ce_n = 1'b0;
        #1;
        check("rst_ready", load_ready, 0);
        check("rst_busy", load_busy, 0);
        check("rst_loaded", loaded, 0);
        check("rst_error", load_error, 0);
        check("rst_3r_unloaded", prom_3r_data, 8'h00);
        check("rst_3s_unloaded", prom_3s_data, 4'h0);
        prom_3r_ce_n = 1'b1; prom_3s_ce_n = 1'b1;
        #1;
        check("rst_3r_ce_off", prom_3r_data, 8'hFF);
        check("rst_3s_ce_off", prom_3s_data, 4'hF);

        // Counting stream, valid held.
        fill(0, 1'b0);
        run_load(0, -1, -1);
        @(negedge clk);
        prom_3r_addr = 9'h1A0; prom_3r_ce_n = 1'b0;
        prom_3s_addr = 9'h003; prom_3s_ce_n = 1'b0;
        #1;
        check("tp_3r_1a0", prom_3r_data, 8'hA0);
        check("tp_3s_003", prom_3s_data, 4'h3);
        check_reads(12);

        // Counting stream again from DONE, valid toggling.
        run_load(1, -1, -1);
        check_reads(8);

        // Random contents, random valid.
        fill(1, 1'b0);
        run_load(2, -1, -1);
        check_reads(16);

        // Reset after 600 beats, then a full reload.
        fill(1, 1'b0);
        run_load(0, 600, -1);
        m_loaded = 1'b0;
        check_reads(8);
        run_load(2, -1, -1);
        check_reads(16);

        // Stray load_start at beat 100 is ignored.
        fill(1, 1'b0);
        run_load(0, -1, 100);
        check_reads(16);

`ifdef CLUT_PROM_CHECKSUM_EN
        // Checksum accepted: all 8'h01 plus 8'h00.
        fill(2, 1'b0);
        run_load(0, -1, -1);
        check("cs_good_loaded", loaded, 1);
        check_reads(8);
        // Checksum rejected: all 8'h01 plus 8'h01.
        fill(2, 1'b1);
        run_load(1, -1, -1);
        check("cs_bad_error", load_error, 1);
        check("cs_bad_loaded", loaded, 0);
        repeat (3) @(negedge clk);
        check("cs_err_held", load_error, 1);
        check_reads(8);
        // Next load_start clears the error.
        fill(1, 1'b0);
        run_load(2, -1, -1);
        check_reads(8);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
